// File: rtl/phase_timer.sv
// phase_timer: countdown timer for traffic-light phase durations.
// The counter steps down once per rising edge of the clk_div strobe. It can be
// paused, extended at runtime by a demand-driven amount, or aborted, and it can
// optionally reload itself on expiry. All outputs come straight from registers.
module phase_timer #(
    parameter int WIDTH     = 8,
    parameter int EXT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_sync,
    input  logic                 clk_div,
    input  logic [WIDTH-1:0]     value,
    input  logic                 start_timer,
    input  logic                 abort,
    input  logic                 pause,
    input  logic                 extend,
    input  logic [EXT_WIDTH-1:0] ext_value,
    input  logic                 reload_en,
    output logic                 expired,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     time_left
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic             clk_div_q_r;
    logic             tick_s;
    logic [WIDTH:0]   add_s;
    logic             dec_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] time_left_r;
    logic [WIDTH-1:0] time_left_s;
    logic             expired_r;
    logic             expired_s;
    logic             done_r;
    logic             done_s;
    logic             busy_r;

    // One tick per rising edge of clk_div, however long it stays high.
    assign tick_s = clk_div & ~clk_div_q_r;

    // Candidate count: remaining + extension - applied tick, saturated at all-ones.
    // The tick only applies while actively running and never below zero, so the
    // subtraction cannot underflow; the extra top bit catches the overflow.
    always_comb begin
        add_s = {(WIDTH+1){1'b0}};
        if (extend) begin
            add_s = {{(WIDTH+1-EXT_WIDTH){1'b0}}, ext_value};
        end else begin
            add_s = {(WIDTH+1){1'b0}};
        end
        dec_s = (state_r == ST_RUN) && !pause && tick_s && (time_left_r != CNT_ZERO);
        sum_s = {1'b0, time_left_r} + add_s - {{WIDTH{1'b0}}, dec_s};
        if (sum_s[WIDTH]) begin
            cnt_s = CNT_MAX;
        end else begin
            cnt_s = sum_s[WIDTH-1:0];
        end
    end

    // Next-state decision with priority abort > start > extend/tick.
    always_comb begin
        state_s     = state_r;
        time_left_s = time_left_r;
        expired_s   = 1'b0;
        done_s      = done_r;
        if (abort) begin
            state_s     = ST_IDLE;
            time_left_s = CNT_ZERO;
            done_s      = 1'b0;
        end else if (start_timer) begin
            state_s     = ST_RUN;
            time_left_s = value;
            done_s      = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (pause) begin
                        // Freeze; any extension still lands, the tick does not.
                        state_s     = ST_PAUSE;
                        time_left_s = cnt_s;
                    end else if (cnt_s == CNT_ZERO) begin
                        // Final tick, or a zero-length load reaching its first cycle.
                        expired_s = 1'b1;
                        if (reload_en) begin
                            state_s     = ST_RUN;
                            time_left_s = value;
                            done_s      = 1'b0;
                        end else begin
                            state_s     = ST_IDLE;
                            time_left_s = CNT_ZERO;
                            done_s      = 1'b1;
                        end
                    end else begin
                        time_left_s = cnt_s;
                    end
                end
                ST_PAUSE: begin
                    time_left_s = cnt_s;
                    if (!pause) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s     = ST_IDLE;
                    time_left_s = CNT_ZERO;
                    done_s      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything without an expiry pulse.
    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            state_r     <= ST_IDLE;
            clk_div_q_r <= 1'b0;
            time_left_r <= CNT_ZERO;
            expired_r   <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            clk_div_q_r <= clk_div;
            time_left_r <= time_left_s;
            expired_r   <= expired_s;
            done_r      <= done_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign expired   = expired_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign time_left = time_left_r;

endmodule
